// File: rtl/vxe_txnreq_encq.sv
// Transaction request queue: buffers read/write requests and streams them out as
// address beats (reads/writes) followed by a data beat (writes only).
module vxe_txnreq_encq #(
  parameter int TXNID_W = 6,
  parameter int ADDR_W  = 37,
  parameter int DEPTH   = 4,
  localparam int VEC_W  = 72,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [TXNID_W-1:0] i_txnid,
  input  logic               i_rnw,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [63:0]        i_data,
  input  logic [7:0]         i_ben,
  output logic               o_req_valid,
  input  logic               i_req_rdy,
  output logic               o_req_beat,
  output logic [VEC_W-1:0]   o_req_vec,
  output logic [CNT_W-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [TXNID_W-1:0] txnid;
    logic               rnw;
    logic [ADDR_W-1:0]  addr;
    logic [63:0]        data;
    logic [7:0]         ben;
  } entry_t;

  typedef enum logic {
    ST_ADDR = 1'b0,
    ST_DATA = 1'b1
  } beat_state_t;

  entry_t      mem [DEPTH];
  entry_t      head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  beat_state_t state;
  beat_state_t state_nxt;
  logic        push;
  logic        pop;
  logic        xfer;

  assign o_ready     = (count != CNT_W'(DEPTH));
  assign o_req_valid = (count != '0);
  assign o_count     = count;
  assign head        = mem[rd_ptr];
  assign push        = nrst & i_valid & o_ready;
  assign xfer        = o_req_valid & i_req_rdy;

  // NOTE: storage carries no reset; the count and pointers alone decide what is
  // valid, so stale contents are never observed and the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{txnid: i_txnid, rnw: i_rnw, addr: i_addr,
                       data: i_data, ben: i_ben};
    end
  end

  // NOTE: every signal assigned here gets its default first so no path through
  // the case leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    if (xfer) begin
      unique case (state)
        ST_ADDR: begin
          if (head.rnw) pop = 1'b1;
          else          state_nxt = ST_DATA;
        end
        ST_DATA: begin
          pop       = 1'b1;
          state_nxt = ST_ADDR;
        end
        default: state_nxt = ST_ADDR;
      endcase
    end
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      state  <= ST_ADDR;
    end else begin
      count <= count_nxt;
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Beat encoding; the vector is forced to zero while nothing is queued.
  always_comb begin
    o_req_beat = (state == ST_DATA);
    o_req_vec  = '0;
    if (o_req_valid) begin
      if (state == ST_DATA) o_req_vec = {head.ben, head.data};
      else                  o_req_vec = VEC_W'({head.txnid, head.rnw, head.addr});
    end
  end

endmodule
